// File: rtl/seq_edge_8b_event_drain_if.sv
// Event output handshake bundle.
//   out_val : an event index is being presented (producer -> consumer)
//   out_idx : bit index of the presented event  (producer -> consumer)
//   out_rdy : consumer accepts the presented event (consumer -> producer)
interface seq_edge_8b_event_drain_if;
  logic       out_val;
  logic       out_rdy;
  logic [2:0] out_idx;

  modport master (output out_val, output out_idx, input  out_rdy);
  modport slave  (input  out_val, input  out_idx, output out_rdy);
endinterface

// File: rtl/seq_edge_8b_event_drain.sv
// Rising-edge event capture on 8 level inputs, queued in a per-bit pending
// register and drained one index at a time over a valid/ready handshake.
//   clk      : single clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : synchronous flush of pending/overflow/output
//   in_      : level inputs, each 0->1 transition is one event
//   overflow : sticky per-bit flag, an event was lost on that bit
//   out_if   : out_val / out_idx / out_rdy handshake (master side)
//
// state | meaning
// IDLE  | nothing presented, out_val = 0
// SEND  | out_idx presented, out_val = 1, held until out_rdy
module seq_edge_8b_event_drain (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [7:0]                       in_,
  output logic [7:0]                       overflow,
  seq_edge_8b_event_drain_if.master        out_if
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overflow_q, overflow_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] edges;
  logic [7:0] remove;
  logic [2:0] sel;
  logic       have;
  logic       take;

  assign edges = in_ & ~prev_q;
  assign have  = |pending_q;

  // Lowest-numbered set pending bit; scanning downward lets the lowest win.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    take       = 1'b0;
    remove     = 8'h00;

    case (state_q)
      IDLE: if (have) take = 1'b1;
      SEND: begin
        if (out_if.out_rdy) begin
          if (have) take = 1'b1;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = SEND;
      idx_d   = sel;
      remove  = 8'h01 << sel;
    end

    // A new edge on the bit being removed re-arms it (not an overflow);
    // an edge on a bit that stays pending is a lost event.
    pending_d  = (pending_q & ~remove) | edges;
    overflow_d = overflow_q | (edges & pending_q & ~remove);

    if (clear) begin
      pending_d  = 8'h00;
      overflow_d = 8'h00;
      state_d    = IDLE;
      idx_d      = idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= 8'h00;
      pending_q  <= 8'h00;
      overflow_q <= 8'h00;
      idx_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= in_;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
    end
  end

  assign out_if.out_val = (state_q == SEND);
  assign out_if.out_idx = idx_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_seq_edge_8b_event_drain.sv
module tb_seq_edge_8b_event_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] in_;
  logic [7:0] overflow;

  seq_edge_8b_event_drain_if out_if ();

  seq_edge_8b_event_drain dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_      (in_),
    .overflow (overflow),
    .out_if   (out_if.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_prev, m_pend, m_ovf;
  logic       m_val;
  logic [2:0] m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 8'h00; m_pend = 8'h00; m_ovf = 8'h00; m_val = 1'b0; m_idx = 3'd0;
  endtask

  // Advance model by one clock using the inputs currently applied, then
  // clock the DUT and compare outputs 1 time unit after the edge.
  task automatic tick();
    logic [7:0] e, np;
    int         lo;
    logic       ld;
    e  = in_ & ~m_prev;
    np = m_pend;
    lo = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_pend[i]) begin lo = i; break; end
    end
    ld = (lo >= 0) && (!m_val || out_if.out_rdy);
    if (clear) begin
      m_pend = 8'h00;
      m_ovf  = 8'h00;
      m_val  = 1'b0;
    end else begin
      if (ld) begin
        np[lo] = 1'b0;
        m_idx  = 3'(lo);
        m_val  = 1'b1;
      end else if (m_val && out_if.out_rdy) begin
        m_val = 1'b0;
      end
      m_ovf  = m_ovf | (e & np);
      m_pend = np | e;
    end
    m_prev = in_;
    @(posedge clk);
    #1;
    chk("mdl_val", {31'd0, out_if.out_val}, {31'd0, m_val});
    if (m_val) chk("mdl_idx", {29'd0, out_if.out_idx}, {29'd0, m_idx});
    chk("mdl_ovf", {24'd0, overflow}, {24'd0, m_ovf});
  endtask

  initial begin
    logic [2:0] held;
    logic       hold;

    reset = 1'b0; clear = 1'b0; in_ = 8'h00; out_if.out_rdy = 1'b0;
    model_reset();
    #12;
    chk("rst_val", {31'd0, out_if.out_val}, 32'd0);
    chk("rst_idx", {29'd0, out_if.out_idx}, 32'd0);
    chk("rst_ovf", {24'd0, overflow}, 32'd0);
    chk("rst_pend", {24'd0, dut.pending_q}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // single edge
    clear = 1'b1; tick();
    clear = 1'b0; tick();
    in_ = 8'b0000_0100; out_if.out_rdy = 1'b1;
    tick(); chk("single_e1_val", {31'd0, out_if.out_val}, 32'd0);
    tick(); chk("single_e2_val", {31'd0, out_if.out_val}, 32'd1);
            chk("single_e2_idx", {29'd0, out_if.out_idx}, 32'd2);
    tick(); chk("single_after_val", {31'd0, out_if.out_val}, 32'd0);

    // priority and back-to-back
    in_ = 8'h00; tick(); tick();
    in_ = 8'b1001_0001;
    tick();
    tick(); chk("b2b_idx0", {29'd0, out_if.out_idx}, 32'd0);
    tick(); chk("b2b_idx4", {29'd0, out_if.out_idx}, 32'd4);
    tick(); chk("b2b_idx7", {29'd0, out_if.out_idx}, 32'd7);
            chk("b2b_val7", {31'd0, out_if.out_val}, 32'd1);
    tick(); chk("b2b_done", {31'd0, out_if.out_val}, 32'd0);
            chk("b2b_ovf", {24'd0, overflow}, 32'd0);

    // backpressure
    in_ = 8'h00; tick();
    out_if.out_rdy = 1'b0; in_ = 8'b0000_1000;
    tick(); tick();
    in_ = 8'b0000_1010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_val", {31'd0, out_if.out_val}, 32'd1);
      chk("bp_idx", {29'd0, out_if.out_idx}, 32'd3);
    end
    out_if.out_rdy = 1'b1;
    tick(); chk("bp_next_idx", {29'd0, out_if.out_idx}, 32'd1);
            chk("bp_next_val", {31'd0, out_if.out_val}, 32'd1);
    tick(); chk("bp_done", {31'd0, out_if.out_val}, 32'd0);

    // overflow
    out_if.out_rdy = 1'b0; in_ = 8'h00; tick();
    in_ = 8'b0010_0000; tick(); tick();
    chk("ovf_send_idx", {29'd0, out_if.out_idx}, 32'd5);
    in_ = 8'h00; tick();
    in_ = 8'b0010_0000; tick();
    chk("ovf_none_yet", {24'd0, overflow}, 32'd0);
    in_ = 8'h00; tick();
    in_ = 8'b0010_0000; tick();
    chk("ovf_set", {24'd0, overflow}, 32'h20);
    out_if.out_rdy = 1'b1;
    tick(); chk("ovf_emit_val", {31'd0, out_if.out_val}, 32'd1);
            chk("ovf_emit_idx", {29'd0, out_if.out_idx}, 32'd5);
    tick(); chk("ovf_once", {31'd0, out_if.out_val}, 32'd0);
    clear = 1'b1; tick();
    chk("ovf_cleared", {24'd0, overflow}, 32'd0);
    clear = 1'b0;

    // clear mid-operation
    out_if.out_rdy = 1'b0; in_ = 8'h00; tick();
    in_ = 8'b0101_0101; tick(); tick();
    in_ = 8'h00; tick();
    in_ = 8'h01; tick();
    chk("clr_pend_pre", {24'd0, dut.pending_q}, 32'h55);
    chk("clr_val_pre", {31'd0, out_if.out_val}, 32'd1);
    clear = 1'b1; out_if.out_rdy = 1'b1; in_ = 8'b0000_0010;
    tick();
    chk("clr_val", {31'd0, out_if.out_val}, 32'd0);
    chk("clr_pend", {24'd0, dut.pending_q}, 32'd0);
    clear = 1'b0;
    tick(); tick();
    chk("clr_disc_val", {31'd0, out_if.out_val}, 32'd0);
    chk("clr_disc_pend", {24'd0, dut.pending_q}, 32'd0);

    // reset mid-transfer, then inputs held high across deassertion
    out_if.out_rdy = 1'b0; in_ = 8'h00; tick();
    in_ = 8'h80; tick(); tick();
    chk("mid_val", {31'd0, out_if.out_val}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_val", {31'd0, out_if.out_val}, 32'd0);
    chk("mid_rst_idx", {29'd0, out_if.out_idx}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("hold_e1_pend", {24'd0, dut.pending_q}, 32'h80);
    tick();
    chk("hold_e2_val", {31'd0, out_if.out_val}, 32'd1);
    chk("hold_e2_idx", {29'd0, out_if.out_idx}, 32'd7);

    // random
    for (int c = 0; c < 60; c++) begin
      in_            = 8'($urandom);
      out_if.out_rdy = 1'($urandom_range(0, 1));
      clear          = ($urandom_range(0, 15) == 0);
      hold           = m_val && !out_if.out_rdy && !clear;
      held           = m_idx;
      tick();
      if (hold) chk("rnd_idx_hold", {29'd0, out_if.out_idx}, {29'd0, held});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_edge_8b_event_drain.md
SEQ_EDGE_8B_EVENT_DRAIN -- requirements
Module: seq_edge_8b_event_drain

Interface
REQ-001 The block SHALL have no parameters; in_ width is fixed at 8 bits and out_idx width at 3 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 clear  input  1  synchronous flush of all captured and queued events.
REQ-005 in_  input  8  level inputs; each 0->1 transition is one event.
REQ-006 out_val  output  1  an event index is presented on out_idx.
REQ-007 out_rdy  input  1  the consumer accepts the presented event.
REQ-008 out_idx  output  3  bit index of the presented event.
REQ-009 overflow  output  8  sticky per-bit flag: an event was lost on that bit.

Function
REQ-010 A prev register SHALL hold in_ from the previous cycle; edges = in_ & ~prev is evaluated every cycle, and prev <= in_ on every clock, including cycles with clear asserted.
REQ-011 A pending register SHALL hold one flag per bit; each edge sets its pending bit at the next clock.
REQ-012 An edge on a bit whose pending flag is already 1, and which is not being moved to the output in the same cycle, SHALL set overflow[bit]; the pending bit stays 1 and the event counts once.
REQ-013 The output register (out_val, out_idx) SHALL be driven by a 2-state FSM: IDLE (out_val=0) and SEND (out_val=1).
REQ-014 In IDLE with pending != 0, the block SHALL load out_idx with the lowest-numbered set pending bit, clear that bit, and enter SEND at the next clock.
REQ-015 In SEND, out_val and out_idx SHALL remain stable until out_val & out_rdy.
REQ-016 On a handshake in SEND:
  - if pending != 0, load the next lowest index, clear that pending bit, and stay in SEND (back-to-back, 1 event/cycle);
  - otherwise, go to IDLE.
REQ-017 An edge arriving in the same cycle its bit is removed from pending SHALL leave the bit set (the new event wins); this is not an overflow.
REQ-018 An edge on the bit currently held in out_idx SHALL set its pending bit as a new event; this is not an overflow.
REQ-019 Latency: an edge visible on in_ before clock edge E1 SHALL set pending at E1 and, if the FSM is in IDLE, SHALL produce out_val=1 after E2.
REQ-020 With clear=1 at a clock edge, the following SHALL happen regardless of any handshake in that cycle, and edges sampled in that cycle are discarded:
  - pending <= 0;
  - overflow <= 0;
  - out_val <= 0;
  - FSM <= IDLE.
REQ-021 out_rdy SHALL be ignored while out_val=0.

Reset
REQ-022 While reset=0, the following SHALL hold asynchronously:
  - prev=0;
  - pending=0;
  - overflow=0;
  - out_val=0;
  - out_idx=0;
  - FSM=IDLE.
REQ-023 Inputs held high across reset deassertion SHALL produce edges at the first clock (prev=0).
REQ-024 Reset asserted mid-transfer SHALL drop the presented event, with no partial handshake.

Verification
REQ-025 Single edge: clear one cycle, then in_=00000000 -> 00000100 with out_rdy=1 -> out_val=1 and out_idx=2 for exactly one cycle, two clocks after the edge; then out_val=0.
REQ-026 Priority and back-to-back: in_ 00000000 -> 10010001 with out_rdy=1 -> out_idx 0, 4, 7 on three consecutive cycles; overflow=00000000.
REQ-027 Backpressure: edge on bit 3 with out_rdy=0 for 5 cycles -> out_val=1 and out_idx=3 held stable; a bit-1 edge arriving meanwhile is presented only after bit 3 is accepted.
REQ-028 Overflow: out_rdy=0, bit-5 edge, then in_ toggles 1->0->1 on bit 5 while it is still pending -> overflow=00100000; after out_rdy=1, bit 5 is emitted exactly once beyond the one in SEND; clear -> overflow=00000000.
REQ-029 Clear mid-operation: pending=01010101 and out_val=1, clear=1 with out_rdy=1 -> next cycle out_val=0 and pending=0; edges sampled during clear are never emitted.
REQ-030 Random: 60 cycles of random in_, out_rdy and clear, checked each cycle against a behavioral model of REQ-010 to REQ-021; out_idx SHALL never change while out_val=1 and out_rdy=0.
